// File: rtl/timer_counter_pkg.sv
// Shared definitions for the programmable timer and the system bridge that maps it:
// register offsets, CTRL bit positions, mode encodings and FSM state encodings.
`timescale 1ns/1ps
package timer_counter_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT    = 2'b00;
    localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counting timer with CTRL/PRESET/COUNT registers and maskable irq.
// Define TIMER_AUTORELOAD_EN to enable the auto-reload mode; otherwise every count is one-shot.
`timescale 1ns/1ps
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             irq
);

    state_e           state_reg, state_next;
    logic             en_reg, en_next;
    logic [1:0]       mode_reg, mode_next;
    logic             im_reg, im_next;
    logic [WIDTH-1:0] preset_reg, preset_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             flag_reg, flag_next;

    logic             ctrl_wr;
    logic             preset_wr;
    logic             autoreload;
    logic [WIDTH-1:0] ctrl_word;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);

`ifdef TIMER_AUTORELOAD_EN
    assign autoreload = (mode_reg == MODE_AUTORELOAD);
`else
    assign autoreload = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            en_reg     <= 1'b0;
            mode_reg   <= MODE_ONESHOT;
            im_reg     <= 1'b0;
            preset_reg <= '0;
            count_reg  <= '0;
            flag_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            en_reg     <= en_next;
            mode_reg   <= mode_next;
            im_reg     <= im_next;
            preset_reg <= preset_next;
            count_reg  <= count_next;
            flag_reg   <= flag_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        en_next     = en_reg;
        mode_next   = mode_reg;
        im_next     = im_reg;
        preset_next = preset_reg;
        count_next  = count_reg;
        flag_next   = flag_reg;

        // A PRESET write or a CTRL write that (re)arms the timer acknowledges the flag;
        // a CTRL write with Enable=0 only touches the mask, so unmasking can expose it.
        if (preset_wr || (ctrl_wr && wd[CTRL_EN_BIT])) begin
            flag_next = 1'b0;
        end
        if (preset_wr) begin
            preset_next = wd;
        end

        case (state_reg)
            ST_IDLE: begin
                if (en_reg) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_next = preset_reg;
                state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!en_reg) begin
                    state_next = ST_IDLE;
                end else if (count_reg <= WIDTH'(1)) begin
                    count_next = '0;
                    flag_next  = 1'b1;
                    state_next = ST_INT;
                end else begin
                    count_next = count_reg - WIDTH'(1);
                end
            end
            ST_INT: begin
                if (autoreload) begin
                    flag_next  = 1'b0;
                    state_next = ST_LOAD;
                end else begin
                    en_next    = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Applied after the FSM so a CPU write overrides the one-shot Enable clear.
        if (ctrl_wr) begin
            en_next = wd[CTRL_EN_BIT];
            im_next = wd[CTRL_IM_BIT];
`ifdef TIMER_AUTORELOAD_EN
            mode_next = wd[CTRL_MODE_MSB:CTRL_MODE_LSB];
`else
            mode_next = MODE_ONESHOT;
`endif
        end
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_EN_BIT] = en_reg;
        ctrl_word[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_reg;
        ctrl_word[CTRL_IM_BIT] = im_reg;
    end

    always_comb begin
        rd = '0;
        case (addr)
            ADDR_CTRL:   rd = ctrl_word;
            ADDR_PRESET: rd = preset_reg;
            ADDR_COUNT:  rd = count_reg;
            default:     rd = '0;
        endcase
    end

    assign irq = flag_reg & im_reg;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: one-shot, auto-reload/mode gating,
// masking, disable, reset mid-count, ignored writes, PRESET=0 and CPU-wins race.
`timescale 1ns/1ps
module tb_timer_counter;
    import timer_counter_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    timer_counter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000ns");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write lands on the next rising edge; returns 1ns after that edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        step(1);
        we   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd, exp);
    endtask

    task automatic do_reset();
        we    = 1'b0;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        addr  = ADDR_CTRL;
        we    = 1'b0;
        wd    = '0;
        step(2);
        reset = 1'b1;

        // Reset state
        rd_chk("rst_ctrl",   ADDR_CTRL,   32'h0);
        rd_chk("rst_preset", ADDR_PRESET, 32'h0);
        rd_chk("rst_count",  ADDR_COUNT,  32'h0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // One-shot, PRESET=5, CTRL=0x9: write edge E0, irq at E7
        wr(ADDR_PRESET, 32'd5);
        wr(ADDR_CTRL, 32'h9);
        step(1);
        rd_chk("os_e1_count", ADDR_COUNT, 32'd0);
        for (int k = 2; k <= 6; k++) begin
            step(1);
            rd_chk($sformatf("os_e%0d_count", k), ADDR_COUNT, 32'(7 - k));
            chk($sformatf("os_e%0d_irq", k), {31'd0, irq}, 32'd0);
        end
        step(1);
        rd_chk("os_e7_count", ADDR_COUNT, 32'd0);
        chk("os_e7_irq", {31'd0, irq}, 32'd1);
        step(1);
        rd_chk("os_en_cleared", ADDR_CTRL, 32'h8);
        step(3);
        chk("os_irq_held", {31'd0, irq}, 32'd1);
        rd_chk("os_count_no_wrap", ADDR_COUNT, 32'd0);
        wr(ADDR_CTRL, 32'h9);
        chk("os_irq_cleared_by_ctrl", {31'd0, irq}, 32'd0);
        do_reset();

        // PRESET=0: irq three edges after enable
        wr(ADDR_PRESET, 32'd0);
        wr(ADDR_CTRL, 32'h9);
        step(2);
        chk("p0_e2_irq", {31'd0, irq}, 32'd0);
        step(1);
        chk("p0_e3_irq", {31'd1 & 32'd0, irq}, 32'd1);
        rd_chk("p0_e3_count", ADDR_COUNT, 32'd0);
        do_reset();

        // PRESET write during CNT does not disturb the running count
        wr(ADDR_PRESET, 32'd4);
        wr(ADDR_CTRL, 32'h9);
        step(2);
        rd_chk("pw_e2_count", ADDR_COUNT, 32'd4);
        step(1);
        rd_chk("pw_e3_count", ADDR_COUNT, 32'd3);
        wr(ADDR_PRESET, 32'd100);
        rd_chk("pw_e4_count", ADDR_COUNT, 32'd2);
        rd_chk("pw_preset_new", ADDR_PRESET, 32'd100);
        step(1);
        rd_chk("pw_e5_count", ADDR_COUNT, 32'd1);
        chk("pw_e5_irq", {31'd0, irq}, 32'd0);
        step(1);
        rd_chk("pw_e6_count", ADDR_COUNT, 32'd0);
        chk("pw_e6_irq", {31'd0, irq}, 32'd1);
        do_reset();

        // Masking: flag set with IM=0, unmask later
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, 32'h1);
        step(4);
        chk("mask_flag_set", {31'd0, dut.flag_reg}, 32'd1);
        chk("mask_irq_low", {31'd0, irq}, 32'd0);
        step(1);
        rd_chk("mask_ctrl_idle", ADDR_CTRL, 32'h0);
        wr(ADDR_CTRL, 32'h8);
        chk("mask_unmask_irq", {31'd0, irq}, 32'd1);
        wr(ADDR_CTRL, 32'h0);
        chk("mask_remask_irq", {31'd0, irq}, 32'd0);
        chk("mask_flag_kept", {31'd0, dut.flag_reg}, 32'd1);
        do_reset();

        // Disable mid-count: the write lands on the edge that brings COUNT to 6
        wr(ADDR_PRESET, 32'd10);
        wr(ADDR_CTRL, 32'h9);
        step(5);
        rd_chk("dis_e5_count", ADDR_COUNT, 32'd7);
        wr(ADDR_CTRL, 32'h0);
        rd_chk("dis_e6_count", ADDR_COUNT, 32'd6);
        step(3);
        rd_chk("dis_frozen", ADDR_COUNT, 32'd6);
        chk("dis_state_idle", 32'(dut.state_reg), 32'(ST_IDLE));
        chk("dis_irq", {31'd0, irq}, 32'd0);
        do_reset();

        // Writes to COUNT / reserved are ignored; reset mid-count
        wr(ADDR_PRESET, 32'd8);
        wr(ADDR_CTRL, 32'h9);
        step(2);
        rd_chk("cw_e2_count", ADDR_COUNT, 32'd8);
        wr(ADDR_COUNT, 32'h1234);
        rd_chk("cw_count_ignored", ADDR_COUNT, 32'd7);
        wr(ADDR_RSVD, 32'hFFFF_FFFF);
        rd_chk("cw_rsvd_reads0", ADDR_RSVD, 32'd0);
        rd_chk("cw_count_after_rsvd", ADDR_COUNT, 32'd6);
        step(2);
        rd_chk("cw_count4", ADDR_COUNT, 32'd4);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        rd_chk("rmid_ctrl",   ADDR_CTRL,   32'h0);
        rd_chk("rmid_preset", ADDR_PRESET, 32'h0);
        rd_chk("rmid_count",  ADDR_COUNT,  32'h0);
        chk("rmid_irq", {31'd0, irq}, 32'd0);
        step(1);
        chk("rmid_irq_next", {31'd0, irq}, 32'd0);
        rd_chk("rmid_count_next", ADDR_COUNT, 32'h0);

        // CPU CTRL write on the one-shot INT edge wins over the Enable clear
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, 32'h9);
        step(3);
        step(1);
        chk("race_e4_irq", {31'd0, irq}, 32'd1);
        wr(ADDR_CTRL, 32'h9);
        rd_chk("race_ctrl_kept", ADDR_CTRL, 32'h9);
        chk("race_irq_cleared", {31'd0, irq}, 32'd0);
        step(2);
        rd_chk("race_restart_count", ADDR_COUNT, 32'd2);
        do_reset();

        // Mode 01 with PRESET=3, CTRL=0xB
        wr(ADDR_PRESET, 32'd3);
        wr(ADDR_CTRL, 32'hB);
`ifdef TIMER_AUTORELOAD_EN
        rd_chk("ar_ctrl", ADDR_CTRL, 32'hB);
        for (int k = 1; k <= 15; k++) begin
            logic [31:0] exp_cnt;
            logic [31:0] exp_irq;
            step(1);
            if (k == 1) begin
                exp_cnt = 32'd0;
            end else begin
                case ((k - 2) % 5)
                    0:       exp_cnt = 32'd3;
                    1:       exp_cnt = 32'd2;
                    2:       exp_cnt = 32'd1;
                    default: exp_cnt = 32'd0;
                endcase
            end
            exp_irq = (k >= 5 && ((k - 5) % 5) == 0) ? 32'd1 : 32'd0;
            rd_chk($sformatf("ar_e%0d_count", k), ADDR_COUNT, exp_cnt);
            chk($sformatf("ar_e%0d_irq", k), {31'd0, irq}, exp_irq);
        end
`else
        rd_chk("nm_ctrl_mode0", ADDR_CTRL, 32'h9);
        step(5);
        chk("nm_e5_irq", {31'd0, irq}, 32'd1);
        step(1);
        rd_chk("nm_e6_ctrl", ADDR_CTRL, 32'h8);
        step(5);
        chk("nm_irq_held", {31'd0, irq}, 32'd1);
        rd_chk("nm_count_zero", ADDR_COUNT, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, which sets the data, PRESET and COUNT width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-004 addr  input  2  word offset in the 16-byte timer window: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
REQ-005 we  input  1  write strobe from the system bridge, qualified by chip select.
REQ-006 wd  input  WIDTH  write data.
REQ-007 rd  output  WIDTH  combinational read data of the register selected by addr.
REQ-008 irq  output  1  interrupt request, routed to one HWInt bit of the CPU.

Function
REQ-009 CTRL SHALL hold bit0 Enable, bits2:1 Mode (00 one-shot, 01 auto-reload), bit3 IM (interrupt mask); bits WIDTH-1:4 SHALL read 0.
REQ-010 Writes SHALL take effect at the clock edge where we==1; writes to COUNT and reserved offset SHALL be ignored; reserved offset SHALL read 0.
REQ-011 The FSM SHALL have states IDLE, LOAD, CNT, INT.
REQ-012 IDLE: Enable==1 -> LOAD; otherwise stay.
REQ-013 LOAD: COUNT<=PRESET; -> CNT.
REQ-014 CNT: Enable==0 -> IDLE with COUNT frozen; COUNT<=1 -> COUNT<=0, IRQ flag set, -> INT; otherwise COUNT<=COUNT-1.
REQ-015 INT in one-shot mode: Enable<=0, -> IDLE, IRQ flag held until the next write to CTRL or PRESET.
REQ-016 INT in auto-reload mode: -> LOAD, IRQ flag cleared on leaving INT (one-cycle pulse).
REQ-017 irq SHALL equal IRQ flag AND IM; clearing IM masks irq without clearing the flag.
REQ-018 After a CTRL write that sets Enable, irq SHALL rise max(PRESET,1)+2 edges later.
REQ-019 A PRESET write while in CNT SHALL NOT alter COUNT until the next LOAD.
REQ-020 If a CPU CTRL write coincides with the one-shot INT clear of Enable, the CPU write SHALL win.
REQ-021 COUNT SHALL never wrap below 0.

Reset
REQ-022 On reset: CTRL=0, PRESET=0, COUNT=0, IRQ flag=0, state IDLE, irq=0, rd reflects these values.
REQ-023 Reset asserted mid-count SHALL abort the count with no residual irq on the next cycle.

Configuration
REQ-024 Macro TIMER_AUTORELOAD_EN defined: Mode 01 SHALL behave as auto-reload per REQ-016.
REQ-025 Macro TIMER_AUTORELOAD_EN undefined: Mode bits SHALL read 00 and every count SHALL behave as one-shot.

Structure
REQ-026 Register offsets, CTRL bit positions, Mode encodings and FSM state encodings SHALL live in the shared package shared with the system bridge.
REQ-027 The block SHALL be a single module with no sub-module; the bridge instantiates it twice (Timer0 0x7F00, Timer1 0x7F10).

Verification
REQ-028 The bench SHALL cover one-shot: PRESET=5, CTRL=0x9 -> COUNT 5,4,3,2,1,0; irq=1 seven edges after the CTRL write; Enable reads 0; irq holds until a CTRL write.
REQ-029 The bench SHALL cover auto-reload (macro defined): PRESET=3, CTRL=0xB -> irq one-cycle pulses every 5 cycles; COUNT reloads to 3.
REQ-030 The bench SHALL cover masking: CTRL=0x1, PRESET=2 -> flag set, irq stays 0; a later write of CTRL=0x8 -> irq=1 next cycle.
REQ-031 The bench SHALL cover a disable mid-count: PRESET=10, enable, then CTRL=0 at COUNT=6 -> COUNT frozen at 6, state IDLE, irq=0.
REQ-032 The bench SHALL cover reset mid-count plus writes to COUNT: write 0x1234 to COUNT -> read unchanged; reset=0 at COUNT=4 -> all registers 0 and irq=0.
REQ-033 The bench SHALL cover PRESET=0 with enable -> irq after 3 edges; and a PRESET write during CNT -> COUNT sequence unaffected.
